// File: rtl/rpn_lan_tx_framer.sv
// ============================================================================
// Module   : rpn_lan_tx_framer
// Brief    : Frames single-beat LAN control messages as a header beat plus a
//            payload beat, tracking a per-destination sequence number.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rpn_lan_tx_framer #(
    parameter int AXIS_DATA_WIDTH      = 64,
    parameter int AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_LAN_TDEST_WIDTH = 8,
    parameter int AXIS_LAN_TUSER_WIDTH = 8,
    parameter int NODE_ID_WIDTH        = 4,
    parameter int NUM_NODES            = 16,
    parameter int SEQ_NUM_WIDTH        = 16
) (
    input  logic                            i_clk,
    input  logic                            i_ap_rst_n,
    input  logic [NODE_ID_WIDTH-1:0]        i_local_node_id,
    input  logic                            i_seq_clear,

    input  logic                            from_finder_tvalid,
    output logic                            from_finder_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]      from_finder_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]      from_finder_tkeep,
    input  logic [AXIS_LAN_TDEST_WIDTH-1:0] from_finder_tid,
    input  logic [AXIS_LAN_TDEST_WIDTH-1:0] from_finder_tdest,
    input  logic [AXIS_LAN_TUSER_WIDTH-1:0] from_finder_tuser,
    input  logic                            from_finder_tlast,

    output logic                            to_LAN_TX_tvalid,
    input  logic                            to_LAN_TX_tready,
    output logic [AXIS_DATA_WIDTH-1:0]      to_LAN_TX_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]      to_LAN_TX_tkeep,
    output logic [AXIS_LAN_TDEST_WIDTH-1:0] to_LAN_TX_tid,
    output logic [AXIS_LAN_TDEST_WIDTH-1:0] to_LAN_TX_tdest,
    output logic [AXIS_LAN_TUSER_WIDTH-1:0] to_LAN_TX_tuser,
    output logic                            to_LAN_TX_tlast,

    output logic [15:0]                     o_drop_count
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_SEND_HDR     = 2'd1,
        S_SEND_PAYLOAD = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [AXIS_DATA_WIDTH-1:0]      r_data;
    logic [AXIS_KEEP_WIDTH-1:0]      r_keep;
    logic [AXIS_LAN_TDEST_WIDTH-1:0] r_id;
    logic [AXIS_LAN_TDEST_WIDTH-1:0] r_dest;
    logic [NODE_ID_WIDTH-1:0]        r_node;
    logic [SEQ_NUM_WIDTH-1:0]        r_seq_cap;
    logic [15:0]                     r_drop_count;

    logic                            w_accept;
    logic                            w_in_range;
    logic                            w_pay_hs;
    logic [NODE_ID_WIDTH-1:0]        w_node;
    logic [SEQ_NUM_WIDTH-1:0]        w_seq_at;
    logic [SEQ_NUM_WIDTH-1:0]        w_seq_vec [NUM_NODES];
    logic [AXIS_DATA_WIDTH-1:0]      w_hdr;
    logic [AXIS_LAN_TUSER_WIDTH-1:0] w_user;

    // Range check uses the whole TUSER so that upper bits mark an invalid node.
    assign w_node     = from_finder_tuser[NODE_ID_WIDTH-1:0];
    assign w_in_range = (32'(from_finder_tuser) < NUM_NODES);
    assign w_accept   = from_finder_tvalid && (r_state == S_IDLE);
    assign w_pay_hs   = (r_state == S_SEND_PAYLOAD) && to_LAN_TX_tready;
    assign w_seq_at   = w_in_range ? w_seq_vec[w_node] : '0;

    // One counter per destination; a clear pulse beats a concurrent increment.
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_seq
        logic [SEQ_NUM_WIDTH-1:0] r_cnt;

        always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
            if (!i_ap_rst_n) begin
                r_cnt <= '0;
            end else if (i_seq_clear) begin
                r_cnt <= '0;
            end else if (w_pay_hs && (r_node == NODE_ID_WIDTH'(g))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_seq_vec[g] = r_cnt;
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_keep       <= '0;
            r_id         <= '0;
            r_dest       <= '0;
            r_node       <= '0;
            r_seq_cap    <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data    <= from_finder_tdata;
                r_keep    <= from_finder_tkeep;
                r_id      <= from_finder_tid;
                r_dest    <= from_finder_tdest;
                r_node    <= w_node;
                r_seq_cap <= w_seq_at;
                if (!w_in_range && (r_drop_count != 16'hFFFF)) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_in_range) begin
                    w_state_nxt = S_SEND_HDR;
                end
            end
            S_SEND_HDR: begin
                if (to_LAN_TX_tready) begin
                    w_state_nxt = S_SEND_PAYLOAD;
                end
            end
            S_SEND_PAYLOAD: begin
                if (to_LAN_TX_tready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_hdr        = '0;
        w_hdr[7:0]   = 8'(r_node);
        w_hdr[15:8]  = 8'(i_local_node_id);
        w_hdr[31:16] = 16'(r_seq_cap);
        w_hdr[39:32] = 8'(r_dest);
        w_hdr[47:40] = 8'(r_id);

        w_user                      = '0;
        w_user[NODE_ID_WIDTH-1:0]   = r_node;
    end

    // Outputs depend only on state and captured fields, never on tready.
    always_comb begin
        from_finder_tready = (r_state == S_IDLE);
        to_LAN_TX_tvalid   = 1'b0;
        to_LAN_TX_tdata    = '0;
        to_LAN_TX_tkeep    = '0;
        to_LAN_TX_tid      = '0;
        to_LAN_TX_tdest    = '0;
        to_LAN_TX_tuser    = '0;
        to_LAN_TX_tlast    = 1'b0;
        case (r_state)
            S_SEND_HDR: begin
                to_LAN_TX_tvalid = 1'b1;
                to_LAN_TX_tdata  = w_hdr;
                to_LAN_TX_tkeep  = '1;
                to_LAN_TX_tid    = r_id;
                to_LAN_TX_tdest  = r_dest;
                to_LAN_TX_tuser  = w_user;
            end
            S_SEND_PAYLOAD: begin
                to_LAN_TX_tvalid = 1'b1;
                to_LAN_TX_tdata  = r_data;
                to_LAN_TX_tkeep  = r_keep;
                to_LAN_TX_tid    = r_id;
                to_LAN_TX_tdest  = r_dest;
                to_LAN_TX_tuser  = w_user;
                to_LAN_TX_tlast  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_drop_count = r_drop_count;

    logic w_unused;
    assign w_unused = from_finder_tlast;

endmodule

`default_nettype wire

// File: tb/tb_rpn_lan_tx_framer.sv
// ============================================================================
// Module   : tb_rpn_lan_tx_framer
// Brief    : Directed plus randomized checking of rpn_lan_tx_framer against a
//            message-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rpn_lan_tx_framer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  local_id;
    logic        seq_clear;
    logic        ff_tvalid;
    logic        ff_tready;
    logic [63:0] ff_tdata;
    logic [7:0]  ff_tkeep;
    logic [7:0]  ff_tid;
    logic [7:0]  ff_tdest;
    logic [7:0]  ff_tuser;
    logic        ff_tlast;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic [7:0]  tx_tid;
    logic [7:0]  tx_tdest;
    logic [7:0]  tx_tuser;
    logic        tx_tlast;
    logic [15:0] drop_count;

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: one sequence number per node plus the drop counter.
    int          exp_seq [16];
    int          exp_drop;

    rpn_lan_tx_framer dut (
        .i_clk              (clk),
        .i_ap_rst_n         (rst_n),
        .i_local_node_id    (local_id),
        .i_seq_clear        (seq_clear),
        .from_finder_tvalid (ff_tvalid),
        .from_finder_tready (ff_tready),
        .from_finder_tdata  (ff_tdata),
        .from_finder_tkeep  (ff_tkeep),
        .from_finder_tid    (ff_tid),
        .from_finder_tdest  (ff_tdest),
        .from_finder_tuser  (ff_tuser),
        .from_finder_tlast  (ff_tlast),
        .to_LAN_TX_tvalid   (tx_tvalid),
        .to_LAN_TX_tready   (tx_tready),
        .to_LAN_TX_tdata    (tx_tdata),
        .to_LAN_TX_tkeep    (tx_tkeep),
        .to_LAN_TX_tid      (tx_tid),
        .to_LAN_TX_tdest    (tx_tdest),
        .to_LAN_TX_tuser    (tx_tuser),
        .to_LAN_TX_tlast    (tx_tlast),
        .o_drop_count       (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_seq[i] = 0;
        exp_drop = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 64'(tx_tvalid), 64'd0);
        chk({tag, "_tdata"},  tx_tdata,       64'd0);
        chk({tag, "_tkeep"},  64'(tx_tkeep),  64'd0);
        chk({tag, "_tid"},    64'(tx_tid),    64'd0);
        chk({tag, "_tdest"},  64'(tx_tdest),  64'd0);
        chk({tag, "_tuser"},  64'(tx_tuser),  64'd0);
        chk({tag, "_tlast"},  64'(tx_tlast),  64'd0);
        chk({tag, "_ready"},  64'(ff_tready), 64'd1);
    endtask

    // One message through the DUT; hs/ps are tready-low cycles on each beat.
    task automatic send_msg(input logic [63:0] d, input logic [7:0] k, input logic [7:0] id,
                            input logic [7:0] dst, input logic [7:0] usr, input int hs,
                            input int ps, input bit clr_pay, output logic [63:0] hdr_seen);
        logic [63:0] eh;
        int          node;
        hdr_seen = '0;
        @(negedge clk);
        chk("idle_ready", 64'(ff_tready), 64'd1);
        chk("idle_tvalid", 64'(tx_tvalid), 64'd0);
        ff_tvalid = 1'b1;
        ff_tdata  = d;
        ff_tkeep  = k;
        ff_tid    = id;
        ff_tdest  = dst;
        ff_tuser  = usr;
        ff_tlast  = 1'($urandom_range(0, 1));
        @(negedge clk);
        ff_tvalid = 1'b0;
        if (usr >= 8'd16) begin
            if (exp_drop < 16'hFFFF) exp_drop++;
            chk("drop_no_output", 64'(tx_tvalid), 64'd0);
            chk("drop_ready", 64'(ff_tready), 64'd1);
            chk("drop_count", 64'(drop_count), 64'(exp_drop));
            return;
        end
        node = int'(usr);
        eh = {16'h0000, id, dst, 16'(exp_seq[node]), 4'h0, local_id, usr};
        for (int i = 0; i <= hs; i++) begin
            tx_tready = (i == hs);
            chk("hdr_tvalid", 64'(tx_tvalid), 64'd1);
            chk("hdr_tdata",  tx_tdata, eh);
            chk("hdr_tkeep",  64'(tx_tkeep), 64'hFF);
            chk("hdr_tlast",  64'(tx_tlast), 64'd0);
            chk("hdr_tuser",  64'(tx_tuser), 64'(usr));
            chk("hdr_tid",    64'(tx_tid), 64'(id));
            chk("hdr_tdest",  64'(tx_tdest), 64'(dst));
            chk("hdr_ready",  64'(ff_tready), 64'd0);
            hdr_seen = tx_tdata;
            @(negedge clk);
        end
        for (int i = 0; i <= ps; i++) begin
            tx_tready = (i == ps);
            seq_clear = clr_pay && (i == ps);
            chk("pay_tvalid", 64'(tx_tvalid), 64'd1);
            chk("pay_tdata",  tx_tdata, d);
            chk("pay_tkeep",  64'(tx_tkeep), 64'(k));
            chk("pay_tlast",  64'(tx_tlast), 64'd1);
            chk("pay_tuser",  64'(tx_tuser), 64'(usr));
            chk("pay_tid",    64'(tx_tid), 64'(id));
            chk("pay_tdest",  64'(tx_tdest), 64'(dst));
            chk("pay_ready",  64'(ff_tready), 64'd0);
            @(negedge clk);
        end
        seq_clear = 1'b0;
        tx_tready = 1'b1;
        exp_seq[node] = (exp_seq[node] + 1) % 65536;
        if (clr_pay) begin
            for (int i = 0; i < 16; i++) exp_seq[i] = 0;
        end
        chk("post_tvalid", 64'(tx_tvalid), 64'd0);
        chk("post_drop_count", 64'(drop_count), 64'(exp_drop));
    endtask

    initial begin
        logic [63:0] hdr;
        logic [7:0]  u;

        rst_n     = 1'b0;
        local_id  = 4'd1;
        seq_clear = 1'b0;
        ff_tvalid = 1'b0;
        ff_tdata  = '0;
        ff_tkeep  = '0;
        ff_tid    = '0;
        ff_tdest  = '0;
        ff_tuser  = '0;
        ff_tlast  = 1'b0;
        tx_tready = 1'b1;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        rst_n = 1'b1;

        // Reference example
        send_msg(64'h1122334455667788, 8'hFF, 8'h02, 8'h05, 8'd3, 0, 0, 1'b0, hdr);
        chk("example_hdr", hdr, 64'h0000020500000103);

        // Per-destination sequence numbers
        send_msg({$urandom, $urandom}, 8'hFF, 8'h11, 8'h22, 8'd3, 0, 0, 1'b0, hdr);
        send_msg({$urandom, $urandom}, 8'h0F, 8'h12, 8'h23, 8'd7, 0, 0, 1'b0, hdr);
        chk("node7_seq0", 64'(hdr[31:16]), 64'd0);
        send_msg({$urandom, $urandom}, 8'hF0, 8'h13, 8'h24, 8'd3, 0, 0, 1'b0, hdr);
        chk("node3_seq2", 64'(hdr[31:16]), 64'd2);

        // Out-of-range destination, then node 0
        send_msg({$urandom, $urandom}, 8'hFF, 8'h01, 8'h01, 8'd16, 0, 0, 1'b0, hdr);
        chk("drop_one", 64'(drop_count), 64'd1);
        send_msg({$urandom, $urandom}, 8'hFF, 8'h01, 8'h01, 8'd0, 0, 0, 1'b0, hdr);
        chk("node0_seq0", 64'(hdr[31:16]), 64'd0);

        // Backpressure on both beats
        send_msg({$urandom, $urandom}, 8'h3C, 8'h44, 8'h55, 8'd5, 5, 3, 1'b0, hdr);
        send_msg({$urandom, $urandom}, 8'hFF, 8'h44, 8'h55, 8'd5, 0, 0, 1'b0, hdr);
        chk("stall_single_incr", 64'(hdr[31:16]), 64'd1);

        // Sequence wrap on node 2
        @(negedge clk);
        force dut.g_seq[2].r_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.g_seq[2].r_cnt;
        exp_seq[2] = 65535;
        send_msg({$urandom, $urandom}, 8'hFF, 8'h02, 8'h02, 8'd2, 0, 0, 1'b0, hdr);
        chk("wrap_ffff", 64'(hdr[31:16]), 64'hFFFF);
        send_msg({$urandom, $urandom}, 8'hFF, 8'h02, 8'h02, 8'd2, 0, 0, 1'b0, hdr);
        chk("wrap_zero", 64'(hdr[31:16]), 64'd0);

        // Clear coinciding with a payload handshake
        for (int i = 0; i < 6; i++) begin
            send_msg({$urandom, $urandom}, 8'hFF, 8'h04, 8'h04, 8'd4, 0, 0, 1'b0, hdr);
        end
        send_msg({$urandom, $urandom}, 8'hFF, 8'h04, 8'h04, 8'd4, 0, 0, 1'b1, hdr);
        chk("clr_captured_seq6", 64'(hdr[31:16]), 64'd6);
        send_msg({$urandom, $urandom}, 8'hFF, 8'h04, 8'h04, 8'd4, 0, 0, 1'b0, hdr);
        chk("clr_node4_seq0", 64'(hdr[31:16]), 64'd0);
        send_msg({$urandom, $urandom}, 8'hFF, 8'h03, 8'h03, 8'd3, 0, 0, 1'b0, hdr);
        chk("clr_node3_seq0", 64'(hdr[31:16]), 64'd0);

        // Randomized traffic including out-of-range nodes
        for (int n = 0; n < 40; n++) begin
            local_id = 4'($urandom_range(0, 15));
            u = 8'($urandom_range(0, 19));
            if ($urandom_range(0, 7) == 0) u = 8'($urandom_range(16, 255));
            send_msg({$urandom, $urandom}, 8'($urandom), 8'($urandom), 8'($urandom), u,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, hdr);
        end

        // Reset during the header beat
        @(negedge clk);
        ff_tvalid = 1'b1;
        ff_tdata  = 64'hDEADBEEFCAFEF00D;
        ff_tkeep  = 8'hFF;
        ff_tuser  = 8'd9;
        tx_tready = 1'b0;
        @(negedge clk);
        ff_tvalid = 1'b0;
        chk("pre_rst_hdr_valid", 64'(tx_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_drop_count", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_tready = 1'b1;
        model_reset();
        chk_reset_outputs("post_rst");
        send_msg({$urandom, $urandom}, 8'hFF, 8'h09, 8'h09, 8'd9, 0, 0, 1'b0, hdr);
        chk("post_rst_seq0", 64'(hdr[31:16]), 64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rpn_lan_tx_framer.md
# rpn_LAN_tx_framer

Downstream neighbour of the LAN node finder, between it and the Network Bridge LAN TX port. Each single-beat control message arrives with the destination node number in TUSER. The block prepends one header beat carrying destination node, source node, a per-destination sequence number and the kernel routing fields, then forwards the payload as the closing beat. Messages addressed to an out-of-range node are dropped and counted.

## Interface

Parameters
- AXIS_DATA_WIDTH, 64, stream data width; must be ≥ 64.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, TKEEP width.
- AXIS_LAN_TDEST_WIDTH, 8, TID/TDEST width (kernel ID).
- AXIS_LAN_TUSER_WIDTH, 8, TUSER width.
- NODE_ID_WIDTH, 4, node number width; must be ≤ 8 and ≤ AXIS_LAN_TUSER_WIDTH.
- NUM_NODES, 16, valid node numbers are 0..NUM_NODES-1; must be ≤ 2^NODE_ID_WIDTH.
- SEQ_NUM_WIDTH, 16, sequence counter width; must be ≤ 16.

Ports
- i_clk  in  1  single clock.
- i_ap_rst_n  in  1  reset, asynchronous assert, active-low.
- i_local_node_id  in  NODE_ID_WIDTH  this node's number; static config.
- i_seq_clear  in  1  single-cycle pulse; clears all sequence counters.
- from_finder_tvalid / from_finder_tready  in / out  1  input handshake.
- from_finder_tdata, _tkeep, _tid, _tdest, _tuser  in  per parameters  message beat; tuser[NODE_ID_WIDTH-1:0] is the destination node.
- from_finder_tlast  in  1  ignored; every input beat is one whole message.
- to_LAN_TX_tvalid / to_LAN_TX_tready  out / in  1  output handshake.
- to_LAN_TX_tdata, _tkeep, _tid, _tdest, _tuser, _tlast  out  per parameters  framed output.
- o_drop_count  out  16  count of dropped messages; saturates at 0xFFFF.

## Operation

- State machine: IDLE, SEND_HDR, SEND_PAYLOAD.
- IDLE:
  - from_finder_tready = 1.
  - On accept, capture tdata, tkeep, tid, tdest, the destination node, and seq[dest node] as it stands at accept.
  - If dest node ≥ NUM_NODES: stay in IDLE, drop the message, o_drop_count +1 (saturating). Nothing is output.
  - Otherwise go to SEND_HDR.
- SEND_HDR:
  - to_LAN_TX_tvalid = 1, tkeep = all ones, tlast = 0.
  - tuser = dest node, zero-extended. tid/tdest = captured values.
  - tdata layout: [7:0] dest node (zero-extended); [15:8] i_local_node_id (zero-extended); [31:16] captured seq (zero-extended); [39:32] captured tdest; [47:40] captured tid; all remaining bits 0.
  - On tready, go to SEND_PAYLOAD.
- SEND_PAYLOAD:
  - tvalid = 1; tdata/tkeep = captured values; tlast = 1; tuser/tid/tdest as in SEND_HDR.
  - On tready: seq[dest] +1, wrapping modulo 2^SEQ_NUM_WIDTH; go to IDLE.
- from_finder_tready = 0 in SEND_HDR and SEND_PAYLOAD.
- Output fields hold stable while tvalid=1 and tready=0.
- i_seq_clear:
  - Zeroes all seq[] on the next edge.
  - If it coincides with a payload handshake, the clear wins: that counter ends at 0.
  - A message already captured keeps its captured seq.
- Counter storage: register array of NUM_NODES × SEQ_NUM_WIDTH, no BRAM.

## Timing

- Reset (async, i_ap_rst_n=0):
  - State = IDLE; all seq[] = 0; o_drop_count = 0; captured registers = 0.
  - Outputs: to_LAN_TX_tvalid = 0, tdata/tkeep/tid/tdest/tuser = 0, tlast = 0, from_finder_tready = 1.
- Reset mid-message aborts the message with no output residue. After release, the next accepted message uses seq 0.
- Latency: header valid the cycle after accept; payload valid the cycle after the header handshake.
- Minimum 3 cycles per valid message with tready held high. A dropped message occupies 1 cycle.
- tvalid is never deasserted without a handshake.
- tvalid is combinational from state only, never from tready.

## Test plan

- Reset, then send tdata=0x1122334455667788, tdest=0x05, tid=0x02, tuser=3, with i_local_node_id=1 and tready=1 → header tdata=0x0000_0205_0000_0103 with tlast=0, then payload 0x1122334455667788 with tlast=1 and tuser=3; 3 cycles total.
- Three messages to node 3 plus one to node 7 → node 3 headers carry seq 0, 1, 2; node 7 header carries seq 0.
- tuser=16 with NUM_NODES=16 → no output beat, o_drop_count=1. A following message to node 0 is framed normally with seq 0.
- Hold tready=0 for 5 cycles on the header, then 3 cycles on the payload → both beats stay stable, from_finder_tready=0 throughout, exactly one increment of seq.
- Preset node 2 to seq 0xFFFF (65535 messages, or force), then send 2 messages → headers show 0xFFFF, then 0x0000.
- Pulse i_seq_clear in the same cycle as the node 4 payload handshake (seq was 6) → next node 4 message shows seq 0. Assert reset during SEND_HDR → tvalid drops immediately and all outputs return to reset values.
